// File: rtl/nibble_ser_pkg.sv
// Shared constants for the nibble serializer: FSM state encoding and parity beat count.
// Optional feature macro: PARITY_EN (adds one even-parity beat after the data bits).
package nibble_ser_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

`ifdef PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

endpackage

// File: rtl/ser_bit_counter.sv
// Beat counter for the serializer: cleared on each word load, advanced per accepted beat.
// Saturates at the final beat index so it never wraps. Honours PARITY_EN via PAR_BITS.
module ser_bit_counter
  import nibble_ser_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH + PAR_BITS - 1);

  assign terminal = (count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Parallel-to-serial converter: loads one WIDTH-bit word on a valid/ready handshake and
// shifts it out one bit per accepted beat. Macro PARITY_EN appends an even-parity beat.
module nibble_serializer
  import nibble_ser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH + PAR_BITS - 2);

  logic             state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count;
  logic             terminal;
  logic             fill_bit;
  logic             load;
  logic             advance;

  assign in_ready = (state == IDLE);
  assign busy     = (state == SHIFT);
  assign load     = in_valid && in_ready;
  assign advance  = (state == SHIFT) && ser_ready;

  // ser_out is taken straight from the shift register end that leaves first.
  assign ser_out  = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];

`ifdef PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (!reset) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ^in_data;
    end
  end

  assign fill_bit = parity;
`else
  assign fill_bit = 1'b0;
`endif

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (load),
    .enable   (advance),
    .count    (count),
    .terminal (terminal)
  );

  // The parity bit enters at the far end on the first shift and reaches the output
  // position exactly after the last data bit has been consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else if (state == IDLE) begin
      if (load) begin
        shift_reg <= in_data;
        ser_valid <= 1'b1;
        ser_last  <= 1'b0;
        state     <= SHIFT;
      end
    end else if (advance) begin
      if (terminal) begin
        state     <= IDLE;
        shift_reg <= '0;
        ser_valid <= 1'b0;
        ser_last  <= 1'b0;
      end else begin
        if (LSB_FIRST) begin
          shift_reg <= {fill_bit, shift_reg[WIDTH-1:1]};
        end else begin
          shift_reg <= {shift_reg[WIDTH-2:0], fill_bit};
        end
        ser_last <= (count == PRE_LAST);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer: an LSB-first and an MSB-first instance share
// stimulus; expected beats are queued at load time and popped as each beat is accepted.
module tb_nibble_serializer;

  localparam int WIDTH = 4;
`ifdef PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct packed {
    logic bit_v;
    logic last;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             ser_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;

  logic in_ready, ser_valid, ser_out, ser_last, busy;
  logic in_ready_m, ser_valid_m, ser_out_m, ser_last_m, busy_m;

  int checks = 0;
  int failures = 0;

  beat_t q_lsb[$];
  beat_t q_msb[$];

  always #5 clk = ~clk;

  nibble_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_out   (ser_out),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  nibble_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_msb (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .in_data   (in_data),
    .ser_valid (ser_valid_m),
    .ser_ready (ser_ready),
    .ser_out   (ser_out_m),
    .ser_last  (ser_last_m),
    .busy      (busy_m)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beats for both bit orders, parity beat appended when enabled.
  task automatic push_word(input logic [WIDTH-1:0] d);
    beat_t b;
    for (int i = 0; i < WIDTH; i++) begin
      b.last  = (PB == 0) && (i == WIDTH - 1);
      b.bit_v = d[i];
      q_lsb.push_back(b);
      b.bit_v = d[WIDTH-1-i];
      q_msb.push_back(b);
    end
    if (PB == 1) begin
      b.bit_v = ^d;
      b.last  = 1'b1;
      q_lsb.push_back(b);
      q_msb.push_back(b);
    end
  endtask

  task automatic load_word(input logic [WIDTH-1:0] d);
    for (int c = 0; c < 20 && !in_ready; c++) step();
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL load_wait in_ready=%b required=1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    push_word(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    checks += 7;
    if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_ser_valid got=%b required=0", ser_valid); end
    if (ser_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_ser_out got=%b required=0", ser_out); end
    if (ser_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_ser_last got=%b required=0", ser_last); end
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b required=1", in_ready); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b required=0", busy); end
    if (ser_valid_m !== 1'b0) begin failures++; $display("[TB] FAIL reset_msb_valid got=%b required=0", ser_valid_m); end
    if (in_ready_m !== 1'b1) begin failures++; $display("[TB] FAIL reset_msb_in_ready got=%b required=1", in_ready_m); end
  endtask

  // 4'b1011: LSB-first gives 1,1,0,1 and MSB-first gives 1,0,1,1.
  task automatic test_bit_order();
    beat_t e, m;
    ser_ready = 1'b1;
    load_word(4'b1011);
    for (int c = 0; c < 40 && q_lsb.size() != 0; c++) begin
      if (ser_valid) begin
        e = q_lsb.pop_front();
        m = q_msb.pop_front();
        checks += 4;
        if (ser_out !== e.bit_v) begin failures++; $display("[TB] FAIL order_lsb_bit got=%b required=%b", ser_out, e.bit_v); end
        if (ser_last !== e.last) begin failures++; $display("[TB] FAIL order_lsb_last got=%b required=%b", ser_last, e.last); end
        if (ser_out_m !== m.bit_v) begin failures++; $display("[TB] FAIL order_msb_bit got=%b required=%b", ser_out_m, m.bit_v); end
        if (ser_last_m !== m.last) begin failures++; $display("[TB] FAIL order_msb_last got=%b required=%b", ser_last_m, m.last); end
      end
      step();
    end
    checks += 3;
    if (q_lsb.size() != 0) begin failures++; $display("[TB] FAIL order_timeout left=%0d required=0", q_lsb.size()); end
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL order_in_ready_after got=%b required=1", in_ready); end
    if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL order_valid_after got=%b required=0", ser_valid); end
  endtask

  task automatic test_backpressure();
    beat_t e, m;
    int n;
    int stall;
    n = 0;
    stall = 0;
    ser_ready = 1'b1;
    load_word(4'b0110);
    for (int c = 0; c < 40 && q_lsb.size() != 0; c++) begin
      if (n == 1 && stall < 3) begin
        ser_ready = 1'b0;
        checks += 3;
        if (ser_out !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_bit got=%b required=1", ser_out); end
        if (ser_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_valid got=%b required=1", ser_valid); end
        if (int'(dut.u_counter.count) !== 1) begin
          failures++;
          $display("[TB] FAIL bp_hold_count got=%0d required=1", dut.u_counter.count);
        end
        stall++;
      end else begin
        ser_ready = 1'b1;
        if (ser_valid) begin
          e = q_lsb.pop_front();
          m = q_msb.pop_front();
          n++;
          checks += 3;
          if (ser_out !== e.bit_v) begin failures++; $display("[TB] FAIL bp_lsb_bit got=%b required=%b", ser_out, e.bit_v); end
          if (ser_last !== e.last) begin failures++; $display("[TB] FAIL bp_lsb_last got=%b required=%b", ser_last, e.last); end
          if (ser_out_m !== m.bit_v) begin failures++; $display("[TB] FAIL bp_msb_bit got=%b required=%b", ser_out_m, m.bit_v); end
        end
      end
      step();
    end
    ser_ready = 1'b1;
    checks++;
    if (q_lsb.size() != 0) begin failures++; $display("[TB] FAIL bp_timeout left=%0d required=0", q_lsb.size()); end
  endtask

  task automatic test_busy_drop();
    beat_t e, m;
    ser_ready = 1'b1;
    load_word(4'b1001);
    in_valid = 1'b1;
    in_data  = 4'hF;
    for (int c = 0; c < 40 && q_lsb.size() != 0; c++) begin
      if (ser_valid) begin
        e = q_lsb.pop_front();
        m = q_msb.pop_front();
        checks += 4;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL busy_in_ready got=%b required=0", in_ready); end
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_flag got=%b required=1", busy); end
        if (ser_out !== e.bit_v) begin failures++; $display("[TB] FAIL busy_pending_bit got=%b required=%b", ser_out, e.bit_v); end
        if (ser_out_m !== m.bit_v) begin failures++; $display("[TB] FAIL busy_pending_msb got=%b required=%b", ser_out_m, m.bit_v); end
      end
      step();
    end
    checks += 2;
    if (q_lsb.size() != 0) begin failures++; $display("[TB] FAIL busy_timeout left=%0d required=0", q_lsb.size()); end
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL busy_idle_ready got=%b required=1", in_ready); end
    push_word(4'hF);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 40 && q_lsb.size() != 0; c++) begin
      if (ser_valid) begin
        e = q_lsb.pop_front();
        m = q_msb.pop_front();
        checks += 2;
        if (ser_out !== e.bit_v) begin failures++; $display("[TB] FAIL busy_next_bit got=%b required=%b", ser_out, e.bit_v); end
        if (ser_last !== e.last) begin failures++; $display("[TB] FAIL busy_next_last got=%b required=%b", ser_last, e.last); end
      end
      step();
    end
    checks++;
    if (q_lsb.size() != 0) begin failures++; $display("[TB] FAIL busy_next_timeout left=%0d required=0", q_lsb.size()); end
  endtask

  task automatic test_mid_reset();
    beat_t e, m;
    ser_ready = 1'b1;
    load_word(4'b1011);
    step();
    step();
    reset = 1'b0;
    step();
    checks += 4;
    if (ser_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%b required=0", ser_valid); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b required=0", busy); end
    if (ser_out !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ser_out got=%b required=0", ser_out); end
    if (ser_last !== 1'b0) begin failures++; $display("[TB] FAIL midrst_last got=%b required=0", ser_last); end
    q_lsb.delete();
    q_msb.delete();
    reset = 1'b1;
    load_word(4'b0001);
    for (int c = 0; c < 40 && q_lsb.size() != 0; c++) begin
      if (ser_valid) begin
        e = q_lsb.pop_front();
        m = q_msb.pop_front();
        checks += 3;
        if (ser_out !== e.bit_v) begin failures++; $display("[TB] FAIL midrst_new_bit got=%b required=%b", ser_out, e.bit_v); end
        if (ser_last !== e.last) begin failures++; $display("[TB] FAIL midrst_new_last got=%b required=%b", ser_last, e.last); end
        if (ser_out_m !== m.bit_v) begin failures++; $display("[TB] FAIL midrst_new_msb got=%b required=%b", ser_out_m, m.bit_v); end
      end
      step();
    end
    checks++;
    if (q_lsb.size() != 0) begin failures++; $display("[TB] FAIL midrst_timeout left=%0d required=0", q_lsb.size()); end
  endtask

  // With parity enabled the model adds the ^data beat carrying ser_last.
  task automatic test_parity();
    beat_t e, m;
    logic [WIDTH-1:0] words [2];
    words[0] = 4'b1011;
    words[1] = 4'b0000;
    ser_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      load_word(words[w]);
      for (int c = 0; c < 40 && q_lsb.size() != 0; c++) begin
        if (ser_valid) begin
          e = q_lsb.pop_front();
          m = q_msb.pop_front();
          checks += 4;
          if (ser_out !== e.bit_v) begin failures++; $display("[TB] FAIL par_lsb_bit w=%0d got=%b required=%b", w, ser_out, e.bit_v); end
          if (ser_last !== e.last) begin failures++; $display("[TB] FAIL par_lsb_last w=%0d got=%b required=%b", w, ser_last, e.last); end
          if (ser_out_m !== m.bit_v) begin failures++; $display("[TB] FAIL par_msb_bit w=%0d got=%b required=%b", w, ser_out_m, m.bit_v); end
          if (ser_last_m !== m.last) begin failures++; $display("[TB] FAIL par_msb_last w=%0d got=%b required=%b", w, ser_last_m, m.last); end
        end
        step();
      end
      checks++;
      if (q_lsb.size() != 0) begin failures++; $display("[TB] FAIL par_timeout w=%0d left=%0d required=0", w, q_lsb.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_backpressure();
    test_busy_drop();
    test_mid_reset();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
